// File: rtl/permutation_iterative.sv
// Iterative ASCON permutation: one round (p_c -> p_s -> p_l) per clock on a 320-bit
// state register, running p^12 (rounds 0..11) or p^6 (rounds 6..11).

module addition_constante (
  input  logic [319:0] state_i,
  input  logic [3:0]   round_i,
  output logic [319:0] state_o
);
  // Round constant ((15-r)<<4)|r is simply {~r, r}; it lands in S_2 only.
  logic [63:0] const_w;
  assign const_w = {56'h0, ~round_i, round_i};
  assign state_o = state_i ^ {128'h0, const_w, 128'h0};
endmodule

module substitution_layer (
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] a0, a2, a4;
  logic [63:0] b0, b1, b2, b3, b4;

  assign {x0, x1, x2, x3, x4} = state_i;

  // Bit-sliced 5-bit S-box applied to all 64 columns in parallel.
  assign a0 = x0 ^ x4;
  assign a4 = x4 ^ x3;
  assign a2 = x2 ^ x1;

  assign b0 = a0 ^ (~x1 & a2);
  assign b1 = x1 ^ (~a2 & x3);
  assign b2 = a2 ^ (~x3 & a4);
  assign b3 = x3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & x1);

  assign state_o = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};
endmodule

module diffusion_lineaire (
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  assign {x0, x1, x2, x3, x4} = state_i;

  assign state_o = {x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
                    x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
                    x2 ^ ror64(x2,  1) ^ ror64(x2,  6),
                    x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
                    x4 ^ ror64(x4,  7) ^ ror64(x4, 41)};
endmodule

module permutation_iterative #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] START_A    = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B    = 4'(12 - ROUNDS_B);

  logic [1:0]   fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [319:0] pc_w, ps_w, pl_w;

  addition_constante u_pc (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (pc_w)
  );

  substitution_layer u_ps (
    .state_i (pc_w),
    .state_o (ps_w)
  );

  diffusion_lineaire u_pl (
    .state_i (ps_w),
    .state_o (pl_w)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = mode_i ? START_B : START_A;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = pl_w;
        if (round_q == LAST_ROUND) begin
          fsm_d = DONE;
        end else if (round_q > LAST_ROUND) begin
          fsm_d   = IDLE;
          round_d = '0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = (fsm_q == DONE);
endmodule

// File: tb/tb_permutation_iterative.sv
// Bench for permutation_iterative: table-driven ASCON round model checked every cycle,
// plus directed latency, round-sequence, reset and held-start scenarios.

module tb_permutation_iterative;
  logic         clock_i = 1'b0;
  logic         resetb_i = 1'b1;
  logic         start_i = 1'b0;
  logic         mode_i = 1'b0;
  logic [319:0] state_i = '0;
  logic [319:0] state_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;

  int tests = 0;
  int fails = 0;

  localparam logic [319:0] REF = {64'h00001000808C0001, 64'h6CB10AD9CA912F80,
                                  64'h691AED630E81901F, 64'h0C4C36A20853217C,
                                  64'h46487B3E06D9D7A8};
  // One full round applied to the all-zero state at round 0, worked out by hand.
  localparam logic [319:0] ZERO_R0 = {64'h001E0F00000000F0, 64'h00000001E0000770,
                                      64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0,
                                      64'h0000000000000000};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  permutation_iterative #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .state_i  (state_i),
    .state_o  (state_o),
    .round_o  (round_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [63:0] m_const(input int r);
    return 64'(((15 - r) << 4) | r);
  endfunction

  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference round: constant into S_2, table S-box per column, then linear mixing.
  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2] = x[2] ^ m_const(r);
    for (int j = 0; j < 64; j++) begin
      v = SBOX[{x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]}];
      for (int i = 0; i < 5; i++) y[i][j] = v[4 - i];
    end
    y[0] = y[0] ^ m_ror(y[0], 19) ^ m_ror(y[0], 28);
    y[1] = y[1] ^ m_ror(y[1], 61) ^ m_ror(y[1], 39);
    y[2] = y[2] ^ m_ror(y[2],  1) ^ m_ror(y[2],  6);
    y[3] = y[3] ^ m_ror(y[3], 10) ^ m_ror(y[3], 17);
    y[4] = y[4] ^ m_ror(y[4],  7) ^ m_ror(y[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model: rounds still to apply, current round, and pending done pulse.
  logic [319:0] m_state = '0;
  int           m_rnd = 0;
  int           m_left = 0;
  logic         m_done = 1'b0;

  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      m_state <= '0;
      m_rnd   <= 0;
      m_left  <= 0;
      m_done  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_state <= m_round(m_state, m_rnd);
      m_left  <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
      else m_rnd <= m_rnd + 1;
    end else if (start_i) begin
      m_state <= state_i;
      m_rnd   <= mode_i ? 6 : 0;
      m_left  <= mode_i ? 6 : 12;
    end
  end

  always @(negedge clock_i) begin
    chk("model_state", state_o, m_state);
    chk("model_round", 320'(round_o), 320'(m_rnd));
    chk("model_busy", 320'(busy_o), 320'(m_left > 0));
    chk("model_done", 320'(done_o), 320'(m_done));
  end

  task automatic run_op(input logic m, input logic [319:0] s, input logic hold,
                        input int exp_lat, input int r0, input string tag);
    int c;
    bit seen;
    c = 0;
    seen = 0;
    start_i = 1'b1;
    mode_i  = m;
    state_i = s;
    while (c < 40 && !seen) begin
      @(negedge clock_i);
      c++;
      if (hold) mode_i = ~mode_i;
      else start_i = 1'b0;
      if (done_o) seen = 1;
      else if (c < exp_lat) chk($sformatf("%s_round%0d", tag, c), 320'(round_o), 320'(r0 + c - 1));
    end
    chk({tag, "_latency"}, 320'(c), 320'(exp_lat));
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (c < 40 && !done_o) begin
      @(negedge clock_i);
      c++;
    end
    chk({tag, "_done_seen"}, 320'(done_o), 320'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    chk("pin_const_r0", m_const(0), 64'hF0);
    chk("pin_const_r11", m_const(11), 64'h4B);
    chk("pin_round0_zero", m_round('0, 0), ZERO_R0);

    start_i = 1'b1;
    state_i = REF;
    #1 resetb_i = 1'b0;
    repeat (3) @(negedge clock_i);
    chk("rst_state", state_o, '0);
    chk("rst_round", 320'(round_o), 320'(0));
    chk("rst_busy", 320'(busy_o), 320'(0));
    chk("rst_done", 320'(done_o), 320'(0));
    resetb_i = 1'b1;
    start_i  = 1'b0;
    @(negedge clock_i);

    run_op(1'b0, REF, 1'b0, 13, 0, "p12");
    @(negedge clock_i);
    chk("p12_done_once", 320'(done_o), 320'(0));
    run_op(1'b1, REF, 1'b0, 7, 6, "p6");
    @(negedge clock_i);
    chk("p6_done_once", 320'(done_o), 320'(0));

    start_i = 1'b1;
    mode_i  = 1'b0;
    state_i = REF;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    #2 resetb_i = 1'b0;
    #1;
    chk("abort_state", state_o, '0);
    chk("abort_busy", 320'(busy_o), 320'(0));
    chk("abort_round", 320'(round_o), 320'(0));
    @(negedge clock_i);
    chk("abort_no_done", 320'(done_o), 320'(0));
    resetb_i = 1'b1;
    @(negedge clock_i);
    run_op(1'b0, REF, 1'b0, 13, 0, "post_abort");

    @(negedge clock_i);
    run_op(1'b1, REF, 1'b1, 7, 6, "held");
    @(negedge clock_i);
    chk("held_idle_busy", 320'(busy_o), 320'(0));
    chk("held_idle_done", 320'(done_o), 320'(0));
    @(negedge clock_i);
    chk("held_restart_busy", 320'(busy_o), 320'(1));
    start_i = 1'b0;
    wait_done("held_second");
    @(negedge clock_i);

    start_i = 1'b1;
    mode_i  = 1'b0;
    state_i = '0;
    @(negedge clock_i);
    start_i = 1'b0;
    chk("zero_start_state", state_o, '0);
    @(negedge clock_i);
    chk("zero_round0_state", state_o, ZERO_R0);
    wait_done("zero_p12");
    @(negedge clock_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/permutation_iterative.md
# permutation_iterative

Iterative ASCON permutation engine wrapping the combinational round stages: `addition_constante` (p_c), `substitution_layer` (p_s) and `diffusion_lineaire` (p_l). The engine owns the 320-bit state register and the 4-bit round counter, and drives that counter into the `round_i` input of `addition_constante`. It executes p^12 (initialisation/finalisation) or p^6 (data processing), one round per clock. It sits directly upstream of `addition_constante` and is controlled by the top-level ASCON FSM through a start/done handshake.

## Interface
- ROUNDS_A, 12, round count for p^a; rounds 0..11.
- ROUNDS_B, 6, round count for p^b; rounds 12-ROUNDS_B..11, i.e. 6..11.
- clock_i  input  1  single clock, rising-edge.
- resetb_i  input  1  asynchronous, active-low reset.
- start_i  input  1  load `state_i` and begin a permutation; sampled only in IDLE.
- mode_i  input  1  0 = p^12, 1 = p^6; sampled together with start_i.
- state_i  input  320 (type_state)  state to permute, S_0..S_4.
- state_o  output  320 (type_state)  state register contents; valid result while done_o=1, held until next start.
- round_o  output  4  current round index, wired to `addition_constante.round_i`.
- busy_o  output  1  high in RUN.
- done_o  output  1  one-cycle pulse; result valid.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 → register ← state_i, round ← (mode_i ? 6 : 0), next RUN.
  - start_i=0 → hold state register and round.
- RUN, each cycle:
  - register ← p_l(p_s(p_c(register, round))).
  - If round = 11 → next DONE, round unchanged.
  - Otherwise round ← round + 1.
- DONE: done_o=1 for exactly one cycle, next IDLE; register and round held.
- start_i in RUN or DONE is ignored; there is no queuing or restart.
- Round counter is 4 bits and never leaves 0..11; values 12..15 are unreachable. A defensive default returns the FSM to IDLE with round 0.
- mode_i is latched only at start; changes during RUN have no effect.
- Only S_2 is touched by p_c; the full state passes through p_s/p_l each round.

## Timing
- Reset (resetb_i=0, asynchronous) forces:
  - FSM = IDLE, state register = 320'h0, round_o = 0, busy_o = 0, done_o = 0.
- Assertion of reset mid-RUN aborts immediately; state_o reads 0 after reset; no done pulse.
- Release is synchronous in effect: first start honoured at the first rising edge with resetb_i=1.
- Latency, counting from edge E0 where start_i is sampled:
  - p^12: rounds applied at E1..E12; done_o high in the cycle after E12 (13 edges after E0); busy_o high E0→E12.
  - p^6: rounds applied at E1..E6; done_o high in the cycle after E6; busy_o high E0→E6.
- round_o during RUN equals the round being applied in that cycle. It is registered, so the combinational path is register → p_c → p_s → p_l → register.
- Back-to-back: start_i may be asserted in the cycle done_o=1; it is ignored (DONE) and must be re-presented in IDLE. Minimum start-to-start spacing is 14 cycles for p^12 and 8 for p^6.

## Test plan
- Reset check: drive resetb_i=0 with start_i=1 → state_o=0, round_o=0, busy_o=0, done_o=0 throughout reset.
- p^12 on the reference state S_0..S_4 = 00001000808C0001, 6CB10AD9CA912F80, 691AED630E81901F, 0C4C36A20853217C, 46487B3E06D9D7A8:
  - round_o steps 0,1,…,11 on consecutive cycles.
  - done_o pulses exactly once, 13 cycles after start.
  - state_o equals the golden software p^12 output.
- p^6 (mode_i=1) on the same input:
  - round_o steps 6..11.
  - done_o pulses 7 cycles after start.
  - state_o equals golden p^6.
- Reset at cycle 5 of a p^12 run:
  - state_o → 0, busy_o → 0 asynchronously; no done_o.
  - A subsequent start produces the correct full result.
- start_i held high continuously plus mode_i toggling every cycle during RUN:
  - Exactly one run with the mode latched at start; no restart.
  - Next run begins only on the edge after DONE, in IDLE.
- First-round sanity: apply p^12 with an all-zero input:
  - The intermediate p_c output in cycle 1 has S_2 = 00000000000000F0.
  - Final state_o matches golden p^12(0).
